// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-port round-robin memory bus arbiter and sequencer
// Optional ACK_N watchdog compiled in with `define ARB_TIMEOUT_EN.
module mem_bus_arbiter #(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          MR0,
    input  logic          MW0,
    input  logic [AW-1:0] ADDR0,
    input  logic [DW-1:0] WDATA0,
    output logic          BUSY0,
    input  logic          MR1,
    input  logic          MW1,
    input  logic [AW-1:0] ADDR1,
    input  logic [DW-1:0] WDATA1,
    output logic          BUSY1,
    output logic [DW-1:0] RDATA,
    output logic [1:0]    ERR,
    output logic          AS_N,
    output logic          WR_N,
    output logic [AW-1:0] BUS_ADDR,
    output logic [DW-1:0] BUS_DOUT,
    input  logic [DW-1:0] BUS_DIN,
    input  logic          ACK_N,
    output logic [1:0]    GRANT,
    output logic [1:0]    STATE
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t state, state_nx;
    logic   req0, req1, pick1, pick_we;
    logic   we, last_grant, timeout;

    assign req0    = MR0 | MW0;
    assign req1    = MR1 | MW1;
    // last_grant=1 means port 1 was served last, so port 0 wins a tie
    assign pick1   = req1 & (~req0 | ~last_grant);
    assign pick_we = pick1 ? MW1 : MW0;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CW-1:0] wait_cnt;
    logic [CW:0]   wait_inc;

    assign wait_inc = {1'b0, wait_cnt} + {{CW{1'b0}}, 1'b1};
    assign timeout  = ACK_N & (wait_inc == (CW+1)'(TIMEOUT_CYCLES));

    always_ff @(posedge CLK) begin
        if (RESET || state != S_ACCESS)
            wait_cnt <= '0;
        else if (ACK_N)
            wait_cnt <= wait_inc[CW-1:0];

        if (RESET)
            ERR <= 2'b00;
        else if (state == S_ACCESS && timeout)
            ERR <= GRANT;
        else
            ERR <= 2'b00;
    end
`else
    assign timeout = 1'b0;
    // Without the watchdog ERR is a constant zero
    assign ERR     = (TIMEOUT_CYCLES < 0) ? 2'b11 : 2'b00;
`endif

    always_ff @(posedge CLK) begin
        if (RESET)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = S_IDLE;
        case (state)
            S_IDLE:   state_nx = (req0 | req1) ? S_ACCESS : S_IDLE;
            S_ACCESS: state_nx = (!ACK_N || timeout) ? S_DONE : S_ACCESS;
            S_DONE:   state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        STATE = state;
        BUSY0 = req0 & ~((state == S_DONE) & GRANT[0]);
        BUSY1 = req1 & ~((state == S_DONE) & GRANT[1]);
    end

    // Transaction attributes are captured once, on the IDLE->ACCESS edge
    always_ff @(posedge CLK) begin
        if (RESET) begin
            AS_N       <= 1'b1;
            WR_N       <= 1'b1;
            GRANT      <= 2'b00;
            RDATA      <= '0;
            BUS_ADDR   <= '0;
            BUS_DOUT   <= '0;
            we         <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req0 | req1) begin
                        GRANT      <= pick1 ? 2'b10 : 2'b01;
                        last_grant <= pick1;
                        BUS_ADDR   <= pick1 ? ADDR1 : ADDR0;
                        BUS_DOUT   <= pick1 ? WDATA1 : WDATA0;
                        we         <= pick_we;
                        AS_N       <= 1'b0;
                        WR_N       <= ~pick_we;
                    end
                end
                S_ACCESS: begin
                    if (!ACK_N && !we)
                        RDATA <= BUS_DIN;
                    if (state_nx == S_DONE) begin
                        AS_N <= 1'b1;
                        WR_N <= 1'b1;
                    end
                end
                S_DONE: GRANT <= 2'b00;
                default: begin
                    AS_N  <= 1'b1;
                    WR_N  <= 1'b1;
                    GRANT <= 2'b00;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed and randomized check of mem_bus_arbiter against a transaction model
module tb_mem_bus_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;
`ifdef ARB_TIMEOUT_EN
    localparam int WR_WAIT = 3;
`else
    localparam int WR_WAIT = 5;
`endif

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          MR0 = 1'b0, MW0 = 1'b0, MR1 = 1'b0, MW1 = 1'b0;
    logic [AW-1:0] ADDR0 = '0, ADDR1 = '0;
    logic [DW-1:0] WDATA0 = '0, WDATA1 = '0;
    logic          BUSY0, BUSY1;
    logic [DW-1:0] RDATA;
    logic [1:0]    ERR;
    logic          AS_N, WR_N;
    logic [AW-1:0] BUS_ADDR;
    logic [DW-1:0] BUS_DOUT;
    logic [DW-1:0] BUS_DIN = '0;
    logic          ACK_N = 1'b1;
    logic [1:0]    GRANT, STATE;

    mem_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(TO)) dut (
        .CLK(CLK), .RESET(RESET),
        .MR0(MR0), .MW0(MW0), .ADDR0(ADDR0), .WDATA0(WDATA0), .BUSY0(BUSY0),
        .MR1(MR1), .MW1(MW1), .ADDR1(ADDR1), .WDATA1(WDATA1), .BUSY1(BUSY1),
        .RDATA(RDATA), .ERR(ERR), .AS_N(AS_N), .WR_N(WR_N),
        .BUS_ADDR(BUS_ADDR), .BUS_DOUT(BUS_DOUT), .BUS_DIN(BUS_DIN), .ACK_N(ACK_N),
        .GRANT(GRANT), .STATE(STATE)
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: who owns the bus, which phase, what was captured
    int          m_phase;   // 0 idle, 1 bus cycle in flight, 2 completion cycle
    int          m_owner;
    int          m_last;
    int          m_wait;
    logic        m_write;
    logic [31:0] m_addr, m_dout, m_rdata;
    logic [1:0]  m_err;
    bit          chk_on = 0;

    task automatic model_step();
        bit r0, r1;
        r0 = MR0 | MW0;
        r1 = MR1 | MW1;
        if (RESET) begin
            m_phase = 0; m_owner = -1; m_last = 1; m_wait = 0; m_write = 0;
            m_addr = 0; m_dout = 0; m_rdata = 0; m_err = 0;
        end else if (m_phase == 0) begin
            m_err = 0;
            if (r0 || r1) begin
                m_owner = (r0 && r1) ? 1 - m_last : (r1 ? 1 : 0);
                m_last  = m_owner;
                m_addr  = (m_owner == 1) ? ADDR1 : ADDR0;
                m_dout  = (m_owner == 1) ? WDATA1 : WDATA0;
                m_write = (m_owner == 1) ? MW1 : MW0;
                m_wait  = 0;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (!ACK_N) begin
                if (!m_write) m_rdata = BUS_DIN;
                m_phase = 2;
            end else begin
                m_wait++;
`ifdef ARB_TIMEOUT_EN
                if (m_wait == TO) begin
                    m_phase = 2;
                    m_err = (m_owner == 1) ? 2'b10 : 2'b01;
                end
`endif
            end
        end else begin
            m_phase = 0; m_owner = -1; m_err = 0;
        end
    endtask

    initial forever begin
        @(posedge CLK);
        model_step();
    end

    always @(negedge CLK) begin
        if (chk_on) begin
            logic [1:0] g;
            g = (m_owner == 1) ? 2'b10 : (m_owner == 0) ? 2'b01 : 2'b00;
            check("cmp_state", STATE, m_phase);
            check("cmp_grant", GRANT, g);
            check("cmp_as_n", AS_N, m_phase != 1);
            check("cmp_wr_n", WR_N, !(m_phase == 1 && m_write));
            check("cmp_bus_addr", BUS_ADDR, m_addr);
            check("cmp_bus_dout", BUS_DOUT, m_dout);
            check("cmp_rdata", RDATA, m_rdata);
            check("cmp_err", ERR, m_err);
            check("cmp_busy0", BUSY0, (MR0 | MW0) && !(m_phase == 2 && m_owner == 0));
            check("cmp_busy1", BUSY1, (MR1 | MW1) && !(m_phase == 2 && m_owner == 1));
        end
    end

    initial begin
        int owners[$];
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk_on = 1;
        check("rst_state", STATE, 0);
        check("rst_as_n", AS_N, 1);
        check("rst_wr_n", WR_N, 1);
        check("rst_grant", GRANT, 0);
        check("rst_err", ERR, 0);
        check("rst_rdata", RDATA, 0);
        check("rst_bus_addr", BUS_ADDR, 0);
        check("rst_bus_dout", BUS_DOUT, 0);
        #1 RESET = 0;

        // Port 0 read, ack on the first ACCESS cycle
        MR0 = 1; ADDR0 = 32'h100; BUS_DIN = 32'hDEADBEEF;
        @(negedge CLK);
        check("rd_as_n", AS_N, 0);
        check("rd_wr_n", WR_N, 1);
        check("rd_grant", GRANT, 2'b01);
        check("rd_bus_addr", BUS_ADDR, 32'h100);
        check("rd_busy_access", BUSY0, 1);
        #1 ACK_N = 0;
        @(negedge CLK);
        check("rd_done_state", STATE, 2);
        check("rd_rdata", RDATA, 32'hDEADBEEF);
        check("rd_busy_done", BUSY0, 0);
        check("rd_grant_done", GRANT, 2'b01);
        #1 MR0 = 0; ACK_N = 1;
        @(negedge CLK);
        check("rd_grant_idle", GRANT, 2'b00);
        check("rd_state_idle", STATE, 0);

        // Port 1 write with delayed ack; inputs changed mid-ACCESS must not leak
        #1 MW1 = 1; ADDR1 = 32'h40; WDATA1 = 32'h12345678;
        for (int c = 0; c <= WR_WAIT; c++) begin
            @(negedge CLK);
            check("wr_state", STATE, 1);
            check("wr_wr_n", WR_N, 0);
            check("wr_dout", BUS_DOUT, 32'h12345678);
            check("wr_addr", BUS_ADDR, 32'h40);
            #1;
            if (c == 1) begin ADDR1 = 32'h5555; WDATA1 = 32'hFFFF0000; end
            if (c == WR_WAIT) ACK_N = 0;
        end
        @(negedge CLK);
        check("wr_done_state", STATE, 2);
        check("wr_rdata_kept", RDATA, 32'hDEADBEEF);
        check("wr_busy1_done", BUSY1, 0);
        #1 MW1 = 0; ACK_N = 1;
        @(negedge CLK);

        // Both requesting continuously: strict alternation starting with port 0
        #1 MR0 = 1; MW1 = 1; ACK_N = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge CLK);
            if (STATE == 1) owners.push_back(GRANT == 2'b10 ? 1 : 0);
            if (GRANT == 2'b01) check("tie_busy1", BUSY1, 1);
            if (GRANT == 2'b10) check("tie_busy0", BUSY0, 1);
        end
        check("tie_count", owners.size(), 4);
        if (owners.size() == 4) begin
            check("tie_o0", owners[0], 0);
            check("tie_o1", owners[1], 1);
            check("tie_o2", owners[2], 0);
            check("tie_o3", owners[3], 1);
        end
        #1 MR0 = 0; MW1 = 0; ACK_N = 1;
        @(negedge CLK);

        // Port 0 arrives while port 1 is mid-cycle
        #1 MR1 = 1; ADDR1 = 32'h200;
        @(negedge CLK);
        #1 MR0 = 1; ADDR0 = 32'h300; ADDR1 = 32'h999;
        @(negedge CLK);
        check("ovl_addr_kept", BUS_ADDR, 32'h200);
        check("ovl_grant", GRANT, 2'b10);
        check("ovl_busy0", BUSY0, 1);
        #1 ACK_N = 0;
        @(negedge CLK);
        check("ovl_busy0_done", BUSY0, 1);
        check("ovl_busy1_done", BUSY1, 0);
        #1 MR1 = 0; ACK_N = 1;
        @(negedge CLK);
        check("ovl_idle_gap", GRANT, 2'b00);
        @(negedge CLK);
        check("ovl_p0_grant", GRANT, 2'b01);
        check("ovl_p0_addr", BUS_ADDR, 32'h300);
        #1 ACK_N = 0;
        @(negedge CLK);
        #1 MR0 = 0; ACK_N = 1;
        @(negedge CLK);

        // Reset while port 0 holds the bus; next tie must still go to port 0
        #1 MR0 = 1;
        @(negedge CLK);
        check("rst_acc_state", STATE, 1);
        #1 RESET = 1;
        @(negedge CLK);
        check("rst_acc_as_n", AS_N, 1);
        check("rst_acc_state0", STATE, 0);
        check("rst_acc_grant", GRANT, 0);
        #1 RESET = 0; MR1 = 1;
        @(negedge CLK);
        check("rst_tie_grant", GRANT, 2'b01);
        #1 ACK_N = 0;
        @(negedge CLK);
        #1 MR0 = 0; ACK_N = 1;
        @(negedge CLK);
        @(negedge CLK);
        check("rst_p1_grant", GRANT, 2'b10);
        #1 ACK_N = 0;
        @(negedge CLK);
        #1 MR1 = 0; ACK_N = 1;
        @(negedge CLK);

        // Port 1 read that is never acknowledged
        #1 MR1 = 1; ADDR1 = 32'h44; BUS_DIN = 32'hCAFEF00D;
`ifdef ARB_TIMEOUT_EN
        for (int c = 0; c < TO; c++) begin
            @(negedge CLK);
            check("to_access", STATE, 1);
        end
        @(negedge CLK);
        check("to_done", STATE, 2);
        check("to_err", ERR, 2'b10);
        check("to_rdata_kept", RDATA, 32'hDEADBEEF);
        check("to_busy1", BUSY1, 0);
        #1 MR1 = 0;
        @(negedge CLK);
        check("to_err_clear", ERR, 2'b00);
`else
        repeat (100) @(negedge CLK);
        check("noto_state", STATE, 1);
        check("noto_as_n", AS_N, 0);
        check("noto_err", ERR, 2'b00);
        #1 MR1 = 0; RESET = 1;
        @(negedge CLK);
        #1 RESET = 0;
`endif

        // Randomized requesters obeying the hold-until-not-busy rule
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge CLK);
            #1;
            if ((MR0 | MW0) && !BUSY0) begin
                if ($urandom % 2) {MW0, MR0} = 2'b00;
                else {MW0, MR0} = 2'($urandom_range(1, 3));
            end else if (!(MR0 | MW0) && ($urandom % 4 == 0)) begin
                {MW0, MR0} = 2'($urandom_range(1, 3));
            end
            if ((MR1 | MW1) && !BUSY1) begin
                if ($urandom % 2) {MW1, MR1} = 2'b00;
                else {MW1, MR1} = 2'($urandom_range(1, 3));
            end else if (!(MR1 | MW1) && ($urandom % 4 == 0)) begin
                {MW1, MR1} = 2'($urandom_range(1, 3));
            end
            ADDR0 = $urandom; ADDR1 = $urandom;
            WDATA0 = $urandom; WDATA1 = $urandom;
            BUS_DIN = $urandom;
            ACK_N = ($urandom % 3) != 0;
            RESET = ($urandom % 500) == 0;
        end
        #1 RESET = 0; MR0 = 0; MW0 = 0; MR1 = 0; MW1 = 0; ACK_N = 0;
        repeat (4) @(negedge CLK);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-port arbiter and transaction sequencer for the shared external memory bus.
- Port 0 is the DLX CPU memory stage. Port 1 is the TinyML accelerator load/store unit.
- Grants one requester at a time using round-robin order and latches that requester's address, data and direction.
- Drives the asynchronous-ack bus handshake (AS_N/WR_N/ACK_N) and returns read data plus a per-port stall (BUSY) in the same style as the existing MR/MW/busy protocol.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- TIMEOUT_CYCLES, 255, number of cycles to wait for ACK_N before abort. Used only with ARB_TIMEOUT_EN.

Ports:
- CLK  in  1  clock
- RESET  in  1  synchronous, active-high reset
- MR0  in  1  port 0 read request, level, held until BUSY0 drops
- MW0  in  1  port 0 write request, level
- ADDR0  in  AW  port 0 address
- WDATA0  in  DW  port 0 write data
- BUSY0  out  1  port 0 stall
- MR1  in  1  port 1 read request
- MW1  in  1  port 1 write request
- ADDR1  in  AW  port 1 address
- WDATA1  in  DW  port 1 write data
- BUSY1  out  1  port 1 stall
- RDATA  out  DW  read data, registered, shared by both ports
- ERR  out  2  per-port timeout error pulse (bit i = port i)
- AS_N  out  1  bus address strobe, active low, registered
- WR_N  out  1  bus write enable, active low, registered
- BUS_ADDR  out  AW  bus address, registered
- BUS_DOUT  out  DW  bus write data, registered
- BUS_DIN  in  DW  bus read data
- ACK_N  in  1  bus acknowledge, active low
- GRANT  out  2  one-hot owner of the current transaction; 00 when idle
- STATE  out  2  current state encoding

Behaviour:
- States: IDLE=0, ACCESS=1, DONE=2. Encoding 3 is illegal and returns to IDLE.
- Port i is requesting when reqi = MRi|MWi. If MRi and MWi are both high, the transaction is a write.
- IDLE:
  - With no request, stay in IDLE.
  - With a request, go to ACCESS at the next edge. In the same edge, latch the winning port's ADDR, WDATA and direction into BUS_ADDR, BUS_DOUT and the internal we flag, and set GRANT.
- Arbitration:
  - A single requester wins.
  - If both request, the port that was not last served wins.
  - last_grant updates on entry to ACCESS.
- ACCESS:
  - AS_N=0. WR_N=~we.
  - If ACK_N is sampled low, go to DONE; on a read, latch BUS_DIN into RDATA in the same edge.
  - Otherwise stay in ACCESS.
- DONE:
  - AS_N=1, WR_N=1. Go to IDLE next edge.
  - GRANT keeps the owner during DONE and clears on return to IDLE.
- BUSYi = reqi & ~(STATE==DONE & GRANT[i]), combinational.
  - The granted port sees exactly one non-busy cycle per transaction.
  - A non-granted requester stays busy throughout.
- Requester rule: the requester deasserts or changes its request during its DONE cycle. A request still asserted in IDLE is a new transaction.
- Minimum latency:
  - Request visible at edge k; AS_N low from k+1.
  - ACK_N low sampled at k+2; DONE during k+2..k+3; RDATA valid from k+2.
  - Back-to-back transactions: 3 cycles each.
- Latched attributes are fixed for the whole transaction. A requester that changes inputs or withdraws during ACCESS does not alter or abort the bus cycle.
- ACK_N low while in IDLE or DONE is ignored.
- RDATA holds its last value until the next completed read. Writes do not modify RDATA.
- Reset values:
  - STATE=IDLE, AS_N=1, WR_N=1, GRANT=00, ERR=00, RDATA=0, BUS_ADDR=0, BUS_DOUT=0.
  - last_grant=port 1, so port 0 wins the first tie.
- Reset in ACCESS: AS_N returns high at the reset edge and no DONE occurs.
- ERR is 00 when the timeout feature is compiled out.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - An 8+ bit wait counter clears on entry to ACCESS and increments each ACCESS cycle with ACK_N high.
  - When the counter reaches TIMEOUT_CYCLES, go to DONE without latching RDATA and pulse ERR[owner] for exactly one cycle, the DONE cycle.
  - BUSY of the owner drops as for a normal completion.
- Not defined: no counter, ACCESS waits indefinitely, ERR tied to 00.

Test Plan:
- Reset, then MR0=1, ADDR0=0x100, ACK_N low one cycle after AS_N falls, BUS_DIN=0xDEADBEEF:
  - AS_N low 1 cycle after the request and WR_N=1.
  - RDATA=0xDEADBEEF.
  - BUSY0 low for exactly one cycle; GRANT=01 then 00.
- MW1=1, ADDR1=0x40, WDATA1=0x12345678, ACK_N delayed 5 cycles:
  - WR_N=0 and BUS_DOUT=0x12345678 held for 6 ACCESS cycles.
  - RDATA unchanged.
- MR0 and MW1 asserted together, both held:
  - Grant order is port 0, port 1, port 0, port 1.
  - Each non-granted port has BUSY=1 throughout.
- MR0 during port 1 ACCESS, with ADDR1 changed mid-ACCESS:
  - BUS_ADDR keeps the latched value.
  - Port 0 is granted 1 cycle after port 1's DONE.
- RESET pulsed while in ACCESS:
  - Next cycle AS_N=1, STATE=0, GRANT=00.
  - A subsequent tie is won by port 0.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, ACK_N held high on a port 1 read:
  - DONE after 4 ACCESS cycles.
  - ERR=10 for one cycle and RDATA unchanged.
  - The same case without the macro stays in ACCESS for 100 cycles.
